// File: rtl/fetch_unit.sv
// PC register and fetch sequencer (IDLE/RUN/HALT) feeding the instruction ROM address.
// Optional one-entry call/return link register is built when FETCH_LINK_EN is defined.
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic              Halt,
    input  logic              Stall,
    input  logic              BranchEn,
    input  logic              BranchRel,
    input  logic [ADDR_W-1:0] Target,
    input  logic              Call,
    input  logic              Ret,
    output logic [ADDR_W-1:0] Address,
    output logic              Valid,
    output logic              Done,
    output logic [CNT_W-1:0]  CycleCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0] pc_inc;

`ifdef FETCH_LINK_EN
    logic [ADDR_W-1:0] link, link_next;
`else
    logic unused_link_ctrl;
    assign unused_link_ctrl = Call ^ Ret;
`endif

    assign pc_inc     = pc + ADDR_W'(1);
    assign Address    = pc;
    assign CycleCount = cnt;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
`ifdef FETCH_LINK_EN
            link  <= '0;
`endif
        end else begin
            state <= state_next;
            pc    <= pc_next;
            cnt   <= cnt_next;
`ifdef FETCH_LINK_EN
            link  <= link_next;
`endif
        end
    end

    // Valid/Done depend only on the state register; PC arithmetic wraps naturally.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        cnt_next   = cnt;
        Valid      = 1'b0;
        Done       = 1'b0;
`ifdef FETCH_LINK_EN
        link_next  = link;
`endif
        case (state)
            IDLE, HALT: begin
                Done = (state == HALT);
                if (Start) begin
                    pc_next    = StartAddr;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                Valid = 1'b1;
                if (cnt != '1)
                    cnt_next = cnt + CNT_W'(1);
                if (Halt) begin
                    state_next = HALT;
                end else if (Stall) begin
                    pc_next = pc;
`ifdef FETCH_LINK_EN
                end else if (Ret) begin
                    pc_next = link;
                end else if (Call) begin
                    link_next = pc_inc;
                    pc_next   = Target;
`endif
                end else if (BranchEn) begin
                    pc_next = BranchRel ? (pc + Target) : Target;
                end else begin
                    pc_next = pc_inc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
